aes_key_expander: RTL and testbench

- Iterative AES-128 key-schedule generator. It sits directly upstream of the full combinational decryption datapath and produces the packed 1408-bit round-key bus that datapath consumes.
- Expands one round key per clock, 10 rounds in total, from a 128-bit cipher key.
- Stores all 11 round keys in decryption order and raises a level-valid flag when the schedule is complete.

---
 rtl/aes_pkg.sv | 51 +++++
 rtl/aes_sbox.sv | 35 +++
 rtl/aes_key_expander.sv | 113 +++++++++++
 tb/tb_aes_key_expander.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// ---------------------------------------------------------------------------
// aes_pkg
// Shared AES-128 constants and types for the key schedule and the cipher
// datapaths.
//   NR       : number of rounds (10 for AES-128)
//   KEY_W    : cipher / round key width
//   SCHED_W  : packed width of all NR+1 round keys
//   RCON     : round constants, indexed by round number 1..10
//   kexp_state_t : key-expander FSM state encoding
//   word_t   : one 32-bit key-schedule word
// ---------------------------------------------------------------------------
package aes_pkg;

    localparam int NR      = 10;
    localparam int KEY_W   = 128;
    localparam int SCHED_W = KEY_W * (NR + 1);

    localparam logic [7:0] RCON [1:10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } kexp_state_t;

    typedef logic [31:0] word_t;

    // Round constant lookup that stays in range for any 4-bit round count;
    // out-of-range rounds return zero.
    function automatic logic [7:0] rcon_lookup(input logic [3:0] round);
        logic [7:0] r;
        case (round)
            4'd1:    r = RCON[1];
            4'd2:    r = RCON[2];
            4'd3:    r = RCON[3];
            4'd4:    r = RCON[4];
            4'd5:    r = RCON[5];
            4'd6:    r = RCON[6];
            4'd7:    r = RCON[7];
            4'd8:    r = RCON[8];
            4'd9:    r = RCON[9];
            4'd10:   r = RCON[10];
            default: r = 8'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// ---------------------------------------------------------------------------
// aes_sbox
// Combinational forward AES S-box (FIPS-197 Fig. 7).
//   a_i : input byte
//   y_o : substituted byte
// ---------------------------------------------------------------------------
module aes_sbox (
    input  logic [7:0] a_i,
    output logic [7:0] y_o
);

    // Table packed with entry 0x00 in the top byte, so entry x lives at
    // bit offset 8*(255-x) = 8*(~x).
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign y_o = SBOX_TABLE[{~a_i, 3'b000} +: 8];

endmodule

// File: rtl/aes_key_expander.sv
// ---------------------------------------------------------------------------
// aes_key_expander
// Iterative AES-128 key schedule: one round key per clock, all 11 keys held
// in decryption order on a packed bus.
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   start      : begin expansion of cipher_key (ignored while busy)
//   cipher_key : 128-bit key, FIPS-197 byte 0 at [127:120]
//   busy       : expansion in progress
//   key_valid  : round_keys complete and stable
//   round_keys : slot j = [128*j +: 128] holds encryption round key 10-j
// ---------------------------------------------------------------------------
module aes_key_expander
    import aes_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [KEY_W-1:0]    cipher_key,
    output logic                busy,
    output logic                key_valid,
    output logic [SCHED_W-1:0]  round_keys
);

    kexp_state_t          state_q;
    logic [3:0]           rcnt_q;
    logic [KEY_W-1:0]     work_q;
    logic [SCHED_W-1:0]   keys_q;
    logic                 busy_q;
    logic                 valid_q;

    // ---------------- one-round key expansion datapath ----------------
    word_t w0, w1, w2, w3;
    word_t rot_w;
    word_t sub_w;
    word_t t_w;
    word_t n0, n1, n2, n3;
    logic [KEY_W-1:0] round_key_d;

    assign w0 = work_q[127:96];
    assign w1 = work_q[95:64];
    assign w2 = work_q[63:32];
    assign w3 = work_q[31:0];

    // RotWord: {a0,a1,a2,a3} -> {a1,a2,a3,a0}
    assign rot_w = {w3[23:0], w3[31:24]};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_subword
            aes_sbox u_sbox (
                .a_i (rot_w[8*gi +: 8]),
                .y_o (sub_w[8*gi +: 8])
            );
        end
    endgenerate

    assign t_w = sub_w ^ {rcon_lookup(rcnt_q), 24'h000000};
    assign n0  = w0 ^ t_w;
    assign n1  = w1 ^ n0;
    assign n2  = w2 ^ n1;
    assign n3  = w3 ^ n2;
    assign round_key_d = {n0, n1, n2, n3};

    // Slot for round rcnt is 10-rcnt; only meaningful while rcnt is 1..10.
    logic [3:0] slot_d;
    assign slot_d = 4'(NR) - rcnt_q;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rcnt_q  <= 4'd0;
            work_q  <= '0;
            keys_q  <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        keys_q[KEY_W*NR +: KEY_W] <= cipher_key;
                        work_q  <= cipher_key;
                        rcnt_q  <= 4'd1;
                        busy_q  <= 1'b1;
                        valid_q <= 1'b0;
                        state_q <= EXPAND;
                    end
                end
                EXPAND: begin
                    keys_q[KEY_W*slot_d +: KEY_W] <= round_key_d;
                    work_q <= round_key_d;
                    rcnt_q <= rcnt_q + 4'd1;
                    if (rcnt_q == 4'(NR)) begin
                        busy_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy       = busy_q;
    assign key_valid  = valid_q;
    assign round_keys = keys_q;

endmodule

// File: tb/tb_aes_key_expander.sv
// ---------------------------------------------------------------------------
// tb_aes_key_expander
// Scoreboard bench: expected schedules are queued as each start is driven
// and compared slot by slot when key_valid rises.
// ---------------------------------------------------------------------------
module tb_aes_key_expander;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [127:0]  cipher_key = '0;
    logic          busy;
    logic          key_valid;
    logic [1407:0] round_keys;

    always #5 clk = ~clk;

    aes_key_expander dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .cipher_key (cipher_key),
        .busy       (busy),
        .key_valid  (key_valid),
        .round_keys (round_keys)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // FIPS-197 Appendix A.1 round keys 0..10
    localparam logic [127:0] FIPS_RK [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };

    typedef struct {
        logic [1407:0] sched;
        logic [10:0]   mask;
        string         name;
    } exp_t;

    exp_t sb_q[$];

    function automatic exp_t fips_exp();
        exp_t e;
        e.sched = '0;
        for (int r = 0; r <= 10; r++) e.sched[128*(10-r) +: 128] = FIPS_RK[r];
        e.mask = 11'h7ff;
        e.name = "fips";
        return e;
    endfunction

    // Zero key: only the published slots (0, 9, 10) are checked.
    function automatic exp_t zero_exp();
        exp_t e;
        e.sched = '0;
        e.sched[128*9  +: 128] = 128'h62636363626363636263636362636363;
        e.sched[128*0  +: 128] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
        e.sched[128*10 +: 128] = 128'h0;
        e.mask = 11'b110_0000_0001;
        e.name = "zero";
        return e;
    endfunction

    // ---------------- monitor: compare on key_valid rising ----------------
    logic valid_prev = 1'b0;

    always @(negedge clk) begin
        if (key_valid && !valid_prev) begin
            if (sb_q.size() == 0) begin
                check("sb_unexpected_valid", 128'(sb_q.size()), 128'd1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                for (int j = 0; j <= 10; j++) begin
                    if (e.mask[j])
                        check($sformatf("%s_slot%0d", e.name, j),
                              round_keys[128*j +: 128], e.sched[128*j +: 128]);
                end
                $display("[TB] schedule %s compared", e.name);
            end
        end
        valid_prev <= key_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one edge (E0); returns 1 ns after E0.
    task automatic drive_start(input logic [127:0] key, input bit push, input exp_t e);
        if (push) sb_q.push_back(e);
        cipher_key = key;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges after E0 until key_valid; optionally pulse start with the
    // zero key after edge pulse_at, or scramble cipher_key every cycle.
    task automatic wait_valid(input int pulse_at, input bit scramble, output int n);
        n = 0;
        while (n < 20) begin
            start = (n == pulse_at) ? 1'b1 : 1'b0;
            if (n == pulse_at) cipher_key = 128'h0;
            if (scramble) cipher_key = {$urandom, $urandom, $urandom, $urandom};
            tick();
            n++;
            if (key_valid) break;
        end
        start = 1'b0;
        if (!key_valid) n = 99;
    endtask

    initial begin
        int   lat;
        exp_t none;
        none = fips_exp();

        // reset
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_valid", 128'(key_valid), 128'd0);
        for (int j = 0; j <= 10; j++)
            check($sformatf("rst_slot%0d", j), round_keys[128*j +: 128], 128'h0);

        // FIPS-197 A.1 with latency
        drive_start(FIPS_RK[0], 1'b1, fips_exp());
        check("fips_busy_after_e0", 128'(busy), 128'd1);
        wait_valid(-1, 1'b0, lat);
        check("fips_latency", 128'(lat), 128'd10);
        check("fips_busy_done", 128'(busy), 128'd0);
        $display("[TB] fips run latency %0d", lat);

        // start re-pulsed mid-expansion must be ignored
        drive_start(FIPS_RK[0], 1'b1, fips_exp());
        wait_valid(3, 1'b0, lat);
        check("ignore_latency", 128'(lat), 128'd10);
        $display("[TB] mid-run start ignored, latency %0d", lat);

        // restart from DONE with the zero key
        drive_start(128'h0, 1'b1, zero_exp());
        check("restart_valid_drop", 128'(key_valid), 128'd0);
        check("restart_busy", 128'(busy), 128'd1);
        wait_valid(-1, 1'b0, lat);
        check("zero_latency", 128'(lat), 128'd10);
        $display("[TB] zero-key run latency %0d", lat);

        // reset sampled at the 5th EXPAND edge aborts with no partial valid
        drive_start(FIPS_RK[0], 1'b0, none);
        for (int k = 0; k < 4; k++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 128'(busy), 128'd0);
        check("abort_valid", 128'(key_valid), 128'd0);
        for (int j = 0; j <= 10; j++)
            check($sformatf("abort_slot%0d", j), round_keys[128*j +: 128], 128'h0);
        for (int k = 0; k < 12; k++) tick();
        check("abort_no_valid", 128'(key_valid), 128'd0);
        $display("[TB] reset mid-expansion checked");

        drive_start(FIPS_RK[0], 1'b1, fips_exp());
        wait_valid(-1, 1'b0, lat);
        check("post_abort_latency", 128'(lat), 128'd10);
        $display("[TB] post-abort run latency %0d", lat);

        // cipher_key scrambled after the accept edge
        drive_start(FIPS_RK[0], 1'b1, fips_exp());
        wait_valid(-1, 1'b1, lat);
        check("scramble_latency", 128'(lat), 128'd10);
        $display("[TB] scrambled-input run latency %0d", lat);

        tick();
        tick();
        check("sb_left", 128'(sb_q.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
